// File: rtl/image_loader_pkg.sv
// Shared constants for the image loader: state encoding, frame geometry and digit width.
// Pixel width comes from `WD (global.v); a 16-bit fallback applies when it is not defined.
`ifndef WD
`define WD 16
`endif

package image_loader_pkg;

  localparam int unsigned IMG_WORDS_DEF = 1024;
  localparam int unsigned AW_DEF        = 10;
  localparam int unsigned DW_DEF        = `WD;
  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned CHK_W         = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_GO    = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

endpackage

// File: rtl/image_loader.sv
// Frame-load front end: streams one image into the image buffer, starts lenet, returns the digit.
// Optional IMG_LOADER_CHKSUM_EN adds a 16-bit per-frame checksum output (res_chksum).
module image_loader
  import image_loader_pkg::*;
#(
  parameter int unsigned IMG_WORDS = IMG_WORDS_DEF,
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  input  logic [DW-1:0]      s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic               cenb,
  output logic [AW-1:0]      ab,
  output logic [DW-1:0]      db,
  output logic               go,
  input  logic               net_ready,
  input  logic [DIGIT_W-1:0] net_digit,
  output logic               res_valid,
  output logic [DIGIT_W-1:0] res_digit,
  output logic               res_err,
  output logic               busy
`ifdef IMG_LOADER_CHKSUM_EN
  ,
  output logic [CHK_W-1:0]   res_chksum
`endif
);

  logic [2:0]    state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic          net_ready_q;
  logic          hs;
  logic          last_word;
  logic          frame_bad;
  logic          rise;
  logic          res_now;

  assign hs        = s_valid & s_ready;
  assign last_word = (cnt == AW'(IMG_WORDS - 1));
  assign rise      = net_ready & ~net_ready_q;
  assign res_now   = (state == ST_WAIT) & rise;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    frame_bad = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (state == ST_IDLE) cnt_d = '0;
        if (hs) begin
          // s_last must coincide exactly with the final word; either mismatch aborts the frame.
          if (s_last != last_word) begin
            frame_bad = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = '0;
          end else if (last_word) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = cnt + 1'b1;
          end
        end
      end
      ST_FLUSH: state_d = ST_GO;
      ST_GO:    state_d = ST_WAIT;
      ST_WAIT:  if (rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      s_ready     <= 1'b0;
      cenb        <= 1'b1;
      ab          <= '0;
      db          <= '0;
      go          <= 1'b0;
      net_ready_q <= 1'b0;
      res_valid   <= 1'b0;
      res_digit   <= '0;
      res_err     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      s_ready     <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
      cenb        <= ~hs;
      if (hs) begin
        ab <= cnt;
        db <= s_data;
      end
      go          <= (state == ST_GO);
      // Sampled in every state so a level already high when WAIT is entered is not a rise.
      net_ready_q <= net_ready;
      res_valid   <= res_now;
      if (res_now) res_digit <= net_digit;
      res_err     <= frame_bad;
    end
  end

`ifdef IMG_LOADER_CHKSUM_EN
  logic [CHK_W-1:0] acc;
  logic [CHK_W-1:0] word16;

  assign word16 = CHK_W'(s_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      res_chksum <= '0;
    end else begin
      if (hs) acc <= ((state == ST_IDLE) ? '0 : acc) + word16;
      if (res_now) res_chksum <= acc;
      else if (frame_bad) res_chksum <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader: frame-level reference model of buffer writes and results.
// Define IMG_LOADER_CHKSUM_EN to also check the checksum output.
module tb_image_loader;
  import image_loader_pkg::*;

  localparam int N  = IMG_WORDS_DEF;
  localparam int AW = AW_DEF;
  localparam int DW = DW_DEF;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic [DW-1:0]      s_data;
  logic               s_last;
  logic               s_ready;
  logic               cenb;
  logic [AW-1:0]      ab;
  logic [DW-1:0]      db;
  logic               go;
  logic               net_ready;
  logic [DIGIT_W-1:0] net_digit;
  logic               res_valid;
  logic [DIGIT_W-1:0] res_digit;
  logic               res_err;
  logic               busy;
`ifdef IMG_LOADER_CHKSUM_EN
  logic [15:0]        res_chksum;
`endif

  image_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .cenb      (cenb),
    .ab        (ab),
    .db        (db),
    .go        (go),
    .net_ready (net_ready),
    .net_digit (net_digit),
    .res_valid (res_valid),
    .res_digit (res_digit),
    .res_err   (res_err),
    .busy      (busy)
`ifdef IMG_LOADER_CHKSUM_EN
    ,
    .res_chksum(res_chksum)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int wr_ab[$];
  int wr_db[$];
  int exp_q[$];
  int go_cnt, go_cyc, rv_cnt, rv_digit, rv_chk, err_cnt, err_ready, hs_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe the DUT once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (!cenb) begin
        wr_ab.push_back(int'(ab));
        wr_db.push_back(int'(db));
      end
      if (go) begin
        go_cnt++;
        go_cyc = cyc;
      end
      if (res_valid) begin
        rv_cnt++;
        rv_digit = int'(res_digit);
`ifdef IMG_LOADER_CHKSUM_EN
        rv_chk = int'(res_chksum);
`endif
      end
      if (res_err) begin
        err_cnt++;
        err_ready = int'(s_ready);
      end
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_ab.delete();
    wr_db.delete();
    go_cnt    = 0;
    rv_cnt    = 0;
    err_cnt   = 0;
    err_ready = 0;
    rv_digit  = -1;
    rv_chk    = -1;
  endtask

  // mode 0: data = index, 1: random, 2: all ones value 1. last_idx < 0 never asserts s_last.
  task automatic send_frame(input int n, input int last_idx, input int mode, input bit gaps);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      int d;
      int t;
      case (mode)
        0:       d = i;
        1:       d = int'($urandom_range(0, 65535));
        default: d = 1;
      endcase
      if (gaps) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = DW'(d);
      s_last  = (i == last_idx);
      t = 0;
      while (!s_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!s_ready) begin
        check_eq("hs_timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      @(negedge clk);
      hs_cyc = cyc;
      exp_q.push_back(d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic verify_writes(input string tag);
    int nbad;
    int n;
    nbad = 0;
    n = (wr_ab.size() < exp_q.size()) ? wr_ab.size() : exp_q.size();
    check_eq({tag, "_wr_cnt"}, wr_ab.size(), exp_q.size());
    for (int i = 0; i < n; i++)
      if (wr_ab[i] != i || wr_db[i] != exp_q[i]) nbad++;
    check_eq({tag, "_wr_bad"}, nbad, 0);
  endtask

  task automatic finish_good(input string tag, input int digit, input bit pre_high,
                             input bit hold_valid);
    int t;
    if (hold_valid) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom_range(0, 65535));
    end
    t = 0;
    while (go_cnt == 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check_eq({tag, "_go_cnt"}, go_cnt, 1);
    check_eq({tag, "_go_lat"}, go_cyc - hs_cyc, 2);
    check_eq({tag, "_busy_wait"}, busy, 1);
    verify_writes(tag);
    if (pre_high) begin
      repeat (8) @(negedge clk);
      check_eq({tag, "_prehigh_nores"}, rv_cnt, 0);
      net_ready = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat ($urandom_range(1, 15)) @(negedge clk);
    check_eq({tag, "_no_early_res"}, rv_cnt, 0);
    s_valid   = 1'b0;
    net_digit = DIGIT_W'(digit);
    net_ready = 1'b1;
    t = 0;
    while (rv_cnt == 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check_eq({tag, "_res_cnt"}, rv_cnt, 1);
    check_eq({tag, "_res_digit"}, rv_digit, digit);
    check_eq({tag, "_digit_held"}, res_digit, digit);
    check_eq({tag, "_busy_idle"}, busy, 0);
    check_eq({tag, "_go_once"}, go_cnt, 1);
    check_eq({tag, "_no_extra_wr"}, wr_ab.size(), exp_q.size());
`ifdef IMG_LOADER_CHKSUM_EN
    begin
      int sum;
      sum = 0;
      foreach (exp_q[i]) sum = (sum + (exp_q[i] & 16'hffff)) & 16'hffff;
      check_eq({tag, "_chksum"}, rv_chk, sum);
    end
`endif
    net_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic finish_err(input string tag);
    repeat (6) @(negedge clk);
    check_eq({tag, "_err_cnt"}, err_cnt, 1);
    check_eq({tag, "_err_ready"}, err_ready, 1);
    check_eq({tag, "_no_go"}, go_cnt, 0);
    check_eq({tag, "_busy"}, busy, 0);
    verify_writes(tag);
`ifdef IMG_LOADER_CHKSUM_EN
    check_eq({tag, "_chksum_zero"}, res_chksum, 0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    net_ready = 1'b0;
    net_digit = '0;
    clear_log();
    #12;
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_cenb", cenb, 1);
    check_eq("rst_go", go, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_err", res_err, 0);
    check_eq("rst_ab", ab, 0);
    check_eq("rst_db", db, 0);
    check_eq("rst_res_digit", res_digit, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", s_ready, 1);

    clear_log();
    send_frame(N, N - 1, 0, 1'b0);
    finish_good("full", 7, 1'b0, 1'b0);

    clear_log();
    send_frame(N, N - 1, 0, 1'b1);
    finish_good("gaps", int'($urandom_range(0, 9)), 1'b0, 1'b1);

    clear_log();
    send_frame(501, 500, 1, 1'b0);
    finish_err("early_last");
    clear_log();
    send_frame(N, N - 1, 1, 1'b0);
    finish_good("after_err", int'($urandom_range(0, 9)), 1'b0, 1'b0);

    clear_log();
    send_frame(N, -1, 1, 1'b0);
    finish_err("no_last");

    net_digit = 4'd3;
    net_ready = 1'b1;
    clear_log();
    send_frame(N, N - 1, 1, 1'b0);
    finish_good("prehigh", 5, 1'b1, 1'b0);

    clear_log();
    send_frame(301, -1, 1, 1'b0);
    check_eq("mid_cenb_low", cenb, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_cenb", cenb, 1);
    check_eq("async_rst_ready", s_ready, 0);
    check_eq("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    send_frame(N, N - 1, 1, 1'b0);
    finish_good("after_rst", int'($urandom_range(0, 9)), 1'b0, 1'b0);

`ifdef IMG_LOADER_CHKSUM_EN
    clear_log();
    send_frame(N, N - 1, 2, 1'b0);
    finish_good("ones", int'($urandom_range(0, 9)), 1'b0, 1'b0);
    check_eq("chk_ones", rv_chk, 16'h0400);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
